// File: rtl/hex_uart_rx_pkg.sv
// Shared constants and helpers for the host debug link hex receiver:
// serial bit period, ASCII character codes and the hex-digit decoder.
package hex_uart_rx_pkg;

   // UART bit period in CLK cycles (shared with the hex transmitter)
   localparam int SERIAL_WCNT = 32'd868;

   // ASCII codes used by the hex protocol
   localparam logic [7:0] ASC_SP    = 8'h20;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_0     = 8'h30;
   localparam logic [7:0] ASC_9     = 8'h39;
   localparam logic [7:0] ASC_LOW_A = 8'h61;
   localparam logic [7:0] ASC_LOW_F = 8'h66;
   localparam logic [7:0] ASC_UP_A  = 8'h41;
   localparam logic [7:0] ASC_UP_F  = 8'h46;

   // Byte receiver states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BITS  = 3'd2,
      ST_STOP  = 3'd3,
      ST_FLUSH = 3'd4
   } rx_state_e;

   // Classification of one received character
   typedef struct packed {
      logic       is_digit;
      logic       is_term;
      logic [3:0] nibble;
   } hex_char_t;

   // Classify a character as hex digit, word terminator or neither
   function automatic hex_char_t hex_decode(input logic [7:0] c);
      hex_char_t r;
      r.is_digit = 1'b0;
      r.is_term  = 1'b0;
      r.nibble   = 4'h0;
      if ((c >= ASC_0) && (c <= ASC_9)) begin
         r.is_digit = 1'b1;
         r.nibble   = 4'(c - ASC_0);
      end else if ((c >= ASC_LOW_A) && (c <= ASC_LOW_F)) begin
         r.is_digit = 1'b1;
         r.nibble   = 4'(c - 8'h57);
      end else if ((c >= ASC_UP_A) && (c <= ASC_UP_F)) begin
         r.is_digit = 1'b1;
         r.nibble   = 4'(c - 8'h37);
      end else if ((c == ASC_SP) || (c == ASC_CR) || (c == ASC_LF)) begin
         r.is_term  = 1'b1;
      end else begin
         r.is_digit = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/hex_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop input synchronizer plus byte FSM.
// Delivers the received byte with a one-cycle strobe, or a one-cycle
// frame error when the stop bit is sampled low.
module hex_uart_rx_byte
   import hex_uart_rx_pkg::*;
#(
   parameter int WCNT = SERIAL_WCNT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       byte_stb,
   output logic       frame_err
);

   localparam int WW = $clog2(WCNT);
   // Last count of the half bit in START and of a full bit elsewhere
   localparam logic [WW-1:0] HALF_LAST = WW'(WCNT / 2 - 1);
   localparam logic [WW-1:0] FULL_LAST = WW'(WCNT - 1);

   logic            rx_meta_r;
   logic            rxs_r;
   rx_state_e       state_r,  state_s;
   logic [WW-1:0]   wcnt_r,   wcnt_s;
   logic [2:0]      bitcnt_r, bitcnt_s;
   logic [7:0]      sreg_r,   sreg_s;
   logic            stb_r,    stb_s;
   logic            ferr_r,   ferr_s;

   // Bring the asynchronous line into the CLK domain (idle level is high)
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta_r <= 1'b1;
         rxs_r     <= 1'b1;
      end else begin
         rx_meta_r <= rxd;
         rxs_r     <= rx_meta_r;
      end
   end

   // Byte FSM state and datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= ST_IDLE;
         wcnt_r   <= '0;
         bitcnt_r <= 3'd0;
         sreg_r   <= 8'h00;
         stb_r    <= 1'b0;
         ferr_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         wcnt_r   <= wcnt_s;
         bitcnt_r <= bitcnt_s;
         sreg_r   <= sreg_s;
         stb_r    <= stb_s;
         ferr_r   <= ferr_s;
      end
   end

   // Next-state logic: mid-bit sampling of start, data and stop bits
   always_comb begin
      state_s  = state_r;
      wcnt_s   = wcnt_r;
      bitcnt_s = bitcnt_r;
      sreg_s   = sreg_r;
      stb_s    = 1'b0;
      ferr_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            wcnt_s   = '0;
            bitcnt_s = 3'd0;
            if (!rxs_r) begin
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (wcnt_r == HALF_LAST) begin
               wcnt_s = '0;
               // A start bit that is already gone is a glitch, not a frame
               if (rxs_r) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_BITS;
               end
            end else begin
               wcnt_s = wcnt_r + WW'(1'b1);
            end
         end
         ST_BITS: begin
            if (wcnt_r == FULL_LAST) begin
               wcnt_s   = '0;
               sreg_s   = {rxs_r, sreg_r[7:1]};
               bitcnt_s = bitcnt_r + 3'd1;
               if (bitcnt_r == 3'd7) begin
                  state_s = ST_STOP;
               end else begin
                  state_s = ST_BITS;
               end
            end else begin
               wcnt_s = wcnt_r + WW'(1'b1);
            end
         end
         ST_STOP: begin
            if (wcnt_r == FULL_LAST) begin
               wcnt_s = '0;
               if (rxs_r) begin
                  stb_s   = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  ferr_s  = 1'b1;
                  state_s = ST_FLUSH;
               end
            end else begin
               wcnt_s = wcnt_r + WW'(1'b1);
            end
         end
         ST_FLUSH: begin
            // Wait out a broken frame until the line returns to idle
            if (rxs_r) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_FLUSH;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   assign rx_byte   = sreg_r;
   assign byte_stb  = stb_r;
   assign frame_err = ferr_r;

endmodule

// File: rtl/hex_uart_rx.sv
// Host debug link input: receives ASCII hex digits over UART, assembles
// them into a DIGIT-nibble word and publishes it on a whitespace
// terminator with a one-cycle VALID pulse. ERR flags bad frames/chars.
module hex_uart_rx
   import hex_uart_rx_pkg::*;
#(
   parameter int DIGIT = 8,
   parameter int WCNT  = SERIAL_WCNT
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RXD,
   output logic [DIGIT*4-1:0] DATA,
   output logic               VALID,
   output logic               ERR
);

   localparam int NDW = $clog2(DIGIT + 1);

   logic [7:0]         rx_byte_s;
   logic               byte_stb_s;
   logic               frame_err_s;
   hex_char_t          dec_s;
   logic [DIGIT*4+3:0] shift_s;

   logic [DIGIT*4-1:0] acc_r,   acc_s;
   logic [NDW-1:0]     ndig_r,  ndig_s;
   logic [DIGIT*4-1:0] data_r,  data_s;
   logic               valid_r, valid_s;
   logic               err_r,   err_s;

   hex_uart_rx_byte #(
      .WCNT (WCNT)
   ) u_byte (
      .CLK       (CLK),
      .RST       (RST),
      .rxd       (RXD),
      .rx_byte   (rx_byte_s),
      .byte_stb  (byte_stb_s),
      .frame_err (frame_err_s)
   );

   // Accumulator, digit count and published outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc_r   <= '0;
         ndig_r  <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         acc_r   <= acc_s;
         ndig_r  <= ndig_s;
         data_r  <= data_s;
         valid_r <= valid_s;
         err_r   <= err_s;
      end
   end

   // Character handling: shift digits in, publish on terminator, flag junk
   always_comb begin
      dec_s   = hex_decode(rx_byte_s);
      // Oldest nibble falls off the top once more than DIGIT digits arrive
      shift_s = {acc_r, dec_s.nibble};
      acc_s   = acc_r;
      ndig_s  = ndig_r;
      data_s  = data_r;
      valid_s = 1'b0;
      err_s   = 1'b0;
      if (frame_err_s) begin
         err_s  = 1'b1;
         acc_s  = '0;
         ndig_s = '0;
      end else if (byte_stb_s) begin
         if (dec_s.is_digit) begin
            acc_s = shift_s[DIGIT*4-1:0];
            if (ndig_r < NDW'(DIGIT)) begin
               ndig_s = ndig_r + NDW'(1'b1);
            end else begin
               ndig_s = ndig_r;
            end
         end else if (dec_s.is_term) begin
            // Terminators with no pending digits are just spacing
            if (ndig_r != '0) begin
               data_s  = acc_r;
               valid_s = 1'b1;
               acc_s   = '0;
               ndig_s  = '0;
            end else begin
               valid_s = 1'b0;
            end
         end else begin
            err_s  = 1'b1;
            acc_s  = '0;
            ndig_s = '0;
         end
      end else begin
         valid_s = 1'b0;
      end
   end

   assign DATA  = data_r;
   assign VALID = valid_r;
   assign ERR   = err_r;

endmodule

// File: tb/tb_hex_uart_rx.sv
// Directed bench for hex_uart_rx with a UART driver at WCNT=16, DIGIT=8.
module tb_hex_uart_rx;
   import hex_uart_rx_pkg::*;

   localparam int WCNT  = 16;
   localparam int DIGIT = 8;

   logic        CLK;
   logic        RST;
   logic        RXD;
   logic [31:0] DATA;
   logic        VALID;
   logic        ERR;

   int errors = 0;
   int checks = 0;

   // Pulse monitor state
   int          n_valid    = 0;
   int          n_err      = 0;
   int          n_both     = 0;
   int          n_long     = 0;
   logic [31:0] last_data  = 32'h0;
   logic        prev_valid = 1'b0;
   logic        prev_err   = 1'b0;

   hex_uart_rx #(
      .DIGIT (DIGIT),
      .WCNT  (WCNT)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .RXD   (RXD),
      .DATA  (DATA),
      .VALID (VALID),
      .ERR   (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Count VALID/ERR pulses, capture published words, catch overlaps and long pulses
   always @(negedge CLK) begin
      if (VALID === 1'b1) begin
         n_valid   <= n_valid + 1;
         last_data <= DATA;
      end
      if (ERR === 1'b1) n_err <= n_err + 1;
      if ((VALID === 1'b1) && (ERR === 1'b1)) n_both <= n_both + 1;
      if (((VALID === 1'b1) && prev_valid) || ((ERR === 1'b1) && prev_err))
         n_long <= n_long + 1;
      prev_valid <= (VALID === 1'b1);
      prev_err   <= (ERR === 1'b1);
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      RXD = 1'b0;
      wait_cycles(WCNT);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         wait_cycles(WCNT);
      end
      RXD = stop_bit;
      wait_cycles(WCNT);
      RXD = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
      wait_cycles(8);
   endtask

   task automatic test_reset;
      RXD = 1'b1;
      RST = 1'b1;
      wait_cycles(3);
      RST = 1'b0;
      wait_cycles(2);
      checks++;
      if (DATA !== 32'h0) begin
         errors++; $display("FAIL reset_data: got %h want %h", DATA, 32'h0);
      end
      checks++;
      if (VALID !== 1'b0 || ERR !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got valid=%b err=%b want 0 0", VALID, ERR);
      end
      checks++;
      if (dut.u_byte.state_r !== ST_IDLE) begin
         errors++; $display("FAIL reset_state: got %0d want %0d", dut.u_byte.state_r, ST_IDLE);
      end
   endtask

   task automatic test_basic;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_str("1a2B ");
      checks++;
      if (n_valid - v0 !== 1) begin
         errors++; $display("FAIL basic_valid_count: got %0d want 1", n_valid - v0);
      end
      checks++;
      if (last_data !== 32'h00001a2b) begin
         errors++; $display("FAIL basic_data: got %h want %h", last_data, 32'h00001a2b);
      end
      checks++;
      if (DATA !== 32'h00001a2b) begin
         errors++; $display("FAIL basic_data_hold: got %h want %h", DATA, 32'h00001a2b);
      end
      checks++;
      if (n_err - e0 !== 0) begin
         errors++; $display("FAIL basic_err_count: got %0d want 0", n_err - e0);
      end
   endtask

   task automatic test_overflow;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_str("123456789\r");
      checks++;
      if (n_valid - v0 !== 1) begin
         errors++; $display("FAIL ovf_valid_count: got %0d want 1", n_valid - v0);
      end
      checks++;
      if (last_data !== 32'h23456789) begin
         errors++; $display("FAIL ovf_data: got %h want %h", last_data, 32'h23456789);
      end
      checks++;
      if (n_err - e0 !== 0) begin
         errors++; $display("FAIL ovf_err_count: got %0d want 0", n_err - e0);
      end
   endtask

   task automatic test_illegal;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_str("12g");
      checks++;
      if (n_err - e0 !== 1) begin
         errors++; $display("FAIL illegal_err_at_g: got %0d want 1", n_err - e0);
      end
      send_str(" ");
      checks++;
      if (n_valid - v0 !== 0) begin
         errors++; $display("FAIL illegal_no_valid_space: got %0d want 0", n_valid - v0);
      end
      send_str("5\n");
      checks++;
      if (n_valid - v0 !== 1) begin
         errors++; $display("FAIL illegal_valid_count: got %0d want 1", n_valid - v0);
      end
      checks++;
      if (last_data !== 32'h00000005) begin
         errors++; $display("FAIL illegal_data: got %h want %h", last_data, 32'h00000005);
      end
      checks++;
      if (n_err - e0 !== 1) begin
         errors++; $display("FAIL illegal_err_total: got %0d want 1", n_err - e0);
      end
   endtask

   task automatic test_framing;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_byte(8'h31, 1'b0);
      wait_cycles(40);
      checks++;
      if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
         errors++; $display("FAIL frame_err: got err=%0d valid=%0d want 1 0", n_err - e0, n_valid - v0);
      end
      checks++;
      if (DATA !== 32'h00000005) begin
         errors++; $display("FAIL frame_data_hold: got %h want %h", DATA, 32'h00000005);
      end
      send_str("7 ");
      checks++;
      if (n_valid - v0 !== 1 || last_data !== 32'h00000007) begin
         errors++; $display("FAIL frame_recover: got n=%0d data=%h want 1 %h", n_valid - v0, last_data, 32'h00000007);
      end
      checks++;
      if (n_err - e0 !== 1) begin
         errors++; $display("FAIL frame_err_total: got %0d want 1", n_err - e0);
      end
   endtask

   task automatic test_glitch;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      RXD = 1'b0;
      wait_cycles(5);
      RXD = 1'b1;
      wait_cycles(30);
      checks++;
      if (dut.u_byte.state_r !== ST_IDLE) begin
         errors++; $display("FAIL glitch_state: got %0d want %0d", dut.u_byte.state_r, ST_IDLE);
      end
      checks++;
      if (n_err - e0 !== 0 || n_valid - v0 !== 0) begin
         errors++; $display("FAIL glitch_pulses: got err=%0d valid=%0d want 0 0", n_err - e0, n_valid - v0);
      end
      send_str("  \n");
      checks++;
      if (n_err - e0 !== 0 || n_valid - v0 !== 0) begin
         errors++; $display("FAIL blank_terms: got err=%0d valid=%0d want 0 0", n_err - e0, n_valid - v0);
      end
      checks++;
      if (DATA !== 32'h00000007) begin
         errors++; $display("FAIL blank_data_hold: got %h want %h", DATA, 32'h00000007);
      end
   endtask

   task automatic test_rst_mid;
      int v0, e0;
      logic [7:0] f_chr;
      f_chr = 8'h66;
      send_str("9");
      v0 = n_valid; e0 = n_err;
      // Start an 'f' frame and abort it with RST during bit 3
      RXD = 1'b0;
      wait_cycles(WCNT);
      for (int i = 0; i < 3; i++) begin
         RXD = f_chr[i];
         wait_cycles(WCNT);
      end
      RXD = f_chr[3];
      wait_cycles(WCNT / 2);
      RST = 1'b1;
      wait_cycles(1);
      RST = 1'b0;
      RXD = 1'b1;
      wait_cycles(1);
      checks++;
      if (DATA !== 32'h0) begin
         errors++; $display("FAIL rst_mid_data: got %h want %h", DATA, 32'h0);
      end
      wait_cycles(40);
      checks++;
      if (n_err - e0 !== 0 || n_valid - v0 !== 0) begin
         errors++; $display("FAIL rst_mid_quiet: got err=%0d valid=%0d want 0 0", n_err - e0, n_valid - v0);
      end
      send_str("3 ");
      checks++;
      if (n_valid - v0 !== 1 || last_data !== 32'h00000003) begin
         errors++; $display("FAIL rst_mid_word: got n=%0d data=%h want 1 %h", n_valid - v0, last_data, 32'h00000003);
      end
      checks++;
      if (n_err - e0 !== 0) begin
         errors++; $display("FAIL rst_mid_err: got %0d want 0", n_err - e0);
      end
   endtask

   task automatic test_back_to_back;
      int v0;
      v0 = n_valid;
      send_str("ABCDEF01 C\n");
      checks++;
      if (n_valid - v0 !== 2 || last_data !== 32'h0000000c) begin
         errors++; $display("FAIL b2b_words: got n=%0d data=%h want 2 %h", n_valid - v0, last_data, 32'h0000000c);
      end
   endtask

   task automatic test_pulse_shape;
      checks++;
      if (n_both !== 0) begin
         errors++; $display("FAIL pulse_overlap: got %0d want 0", n_both);
      end
      checks++;
      if (n_long !== 0) begin
         errors++; $display("FAIL pulse_width: got %0d want 0", n_long);
      end
   endtask

   initial begin
      RST = 1'b1;
      RXD = 1'b1;
      test_reset();
      test_basic();
      test_overflow();
      test_illegal();
      test_framing();
      test_glitch();
      test_rst_mid();
      test_back_to_back();
      test_pulse_shape();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_uart_rx.md
# hex_uart_rx

Serial-side input path of the host debug link: receives 8N1 UART characters on RXD, decodes ASCII hexadecimal digits and assembles them into a DIGIT-nibble word. It is the counterpart of the LCD/serial hex transmitter and uses the same bit period (`SERIAL_WCNT` from define.v). A whitespace terminator publishes the word on DATA with a one-cycle VALID pulse. Used for host-injected parameters and test vectors.

## Interface
- DIGIT, 8: number of hex nibbles in DATA.
- WCNT, `SERIAL_WCNT`: UART bit period in CLK cycles; minimum 4.
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- RXD  in  1  asynchronous serial input, idle high.
- DATA  out  DIGIT*4  last published word, most recent digit in DATA[3:0].
- VALID  out  1  one-cycle pulse: DATA was updated this cycle.
- ERR  out  1  one-cycle pulse: framing error or illegal character.

## Operation
- RXD passes through a 2-flop synchronizer (rxs). All sampling uses rxs.
- Byte FSM: IDLE, START, BITS, STOP, FLUSH.
  - IDLE: rxs==0 -> START, wcnt=0.
  - START: count WCNT/2 cycles, then sample. rxs==1 -> IDLE (glitch, no byte, no ERR). rxs==0 -> BITS.
  - BITS: sample every WCNT cycles, 8 bits LSB first into sreg.
  - STOP: after WCNT cycles, sample. rxs==1 -> byte strobe, then IDLE. rxs==0 -> framing error -> FLUSH.
  - FLUSH: wait for rxs==1, then IDLE.
- Character decode on a byte strobe:
  - '0'-'9' (0x30-0x39) -> nibble c-0x30.
  - 'a'-'f' (0x61-0x66) -> nibble c-0x57.
  - 'A'-'F' (0x41-0x46) -> nibble c-0x37.
  - Digit: acc <= {acc[DIGIT*4-5:0], nibble}; ndig <= sat(ndig+1, DIGIT).
  - Terminator, space 0x20, CR 0x0D or LF 0x0A:
    - ndig>0: DATA <= acc, VALID=1, acc <= 0, ndig <= 0.
    - ndig==0: ignored (no VALID, no ERR).
  - Any other byte: ERR=1, acc <= 0, ndig <= 0.
- Framing error: ERR=1, acc <= 0, ndig <= 0. The byte is discarded.
- Overflow: more than DIGIT digits keeps only the last DIGIT nibbles. No error.
- Word is zero-extended when fewer than DIGIT digits are received.
- ndig width is clog2(DIGIT+1) bits.

## Timing
- Reset values: DATA=0, VALID=0, ERR=0, FSM=IDLE, acc=0, ndig=0, sreg=0, wcnt=0, synchronizer flops=1.
- RST mid-frame aborts the frame and discards the partial word. The next falling edge starts a fresh frame.
- Start-bit edge to START entry: 2 cycles (synchronizer latency).
- Stop-bit sample cycle = cycle S.
  - The byte strobe is registered in S.
  - VALID/ERR and DATA update at S+1.
  - Framing ERR also fires at S+1.
- VALID and ERR are never asserted in the same cycle. Each is high exactly 1 cycle.
- DATA holds between VALID pulses.
- Back-to-back frames: a start bit arriving immediately after the stop sample is accepted. IDLE is re-entered at S+1, and the minimum stop length tolerated is WCNT/2+2 cycles.
- Bit sampling is at bit centre ±1 cycle. The receiver tolerates ±2% baud mismatch at WCNT≥50.

## Structure
- `SERIAL_WCNT` and the ASCII constants (space, CR, LF, digit ranges) belong in the shared define.v.
- Sub-module uart_rx_byte: synchronizer plus byte FSM. Outputs a byte, a byte strobe and a frame error.
- The top level contains the hex decode, accumulator, ndig and output registers.

## Test plan
Bench uses WCNT=16, DIGIT=8 and a UART driver model.
- Send "1a2B " -> one VALID, DATA=32'h00001a2b, ERR never high.
- Send "123456789\r" -> VALID with DATA=32'h23456789 (overflow keeps last 8 digits).
- Send "12g 5\n":
  - ERR pulse at 'g'.
  - No VALID at the space.
  - Then VALID with DATA=32'h00000005.
- Frame 0x31 with stop bit forced 0, then hold RXD high, then send "7 " -> ERR once, then VALID with DATA=32'h00000007.
- RXD low glitch of 5 cycles -> no strobe, no ERR, FSM back in IDLE. Send "  \n" -> no VALID, no ERR.
- Assert RST for 1 cycle mid-BITS of a 'f' frame, then send "3 " -> DATA=32'h00000003. VALID/ERR stay 0 until then.
